// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage pipeline sequencer (stall/flush/redirect plus memory-wait watchdog).
// Optional performance counters are enabled with `define PIPE_CTRL_PERF_EN.
`default_nettype none

module pipe_ctrl #(
  parameter int XLEN        = 32,
  parameter int TMO_W       = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hazard_stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            dmem_req,
  input  logic            dmem_ack,
  output logic            pc_en,
  output logic            if_id_en,
  output logic            id_exe_en,
  output logic            exe_mem_en,
  output logic            mem_wb_en,
  output logic            if_id_flush,
  output logic            id_exe_flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0]     hazard_cycles,
  output logic [31:0]     mem_wait_cycles,
`endif
  output logic            mem_timeout_err
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_ERROR    = 2'd3
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

  state_t            state, state_n;
  logic [TMO_W-1:0]  wait_cnt, wait_cnt_n;
  logic [XLEN-1:0]   rpc_n;
  logic [4:0]        en;        // {pc, if_id, id_exe, exe_mem, mem_wb}
  logic              hazard_evt;
  logic              mem_stall;

  assign mem_stall = dmem_req && !dmem_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      redirect_pc <= '0;
    end else begin
      state       <= state_n;
      wait_cnt    <= wait_cnt_n;
      redirect_pc <= rpc_n;
    end
  end

  always_comb begin
    state_n         = state;
    wait_cnt_n      = wait_cnt;
    rpc_n           = redirect_pc;
    en              = 5'b00000;
    if_id_flush     = 1'b0;
    id_exe_flush    = 1'b0;
    redirect_valid  = 1'b0;
    mem_timeout_err = 1'b0;
    hazard_evt      = 1'b0;

    case (state)
      ST_RUN: begin
        if (mem_stall) begin
          state_n    = ST_MEM_WAIT;
          wait_cnt_n = TMO_W'(1);
        end else if (branch_taken) begin
          en           = 5'b11111;
          if_id_flush  = 1'b1;
          id_exe_flush = 1'b1;
          rpc_n        = branch_target;
          state_n      = ST_REDIRECT;
        end else if (hazard_stall) begin
          // Hold PC and IF/ID, inject a bubble into ID/EXE, let older stages drain.
          en           = 5'b00111;
          id_exe_flush = 1'b1;
          hazard_evt   = 1'b1;
        end else begin
          en = 5'b11111;
        end
      end

      ST_MEM_WAIT: begin
        if (dmem_ack) begin
          en         = 5'b11111;
          state_n    = ST_RUN;
          wait_cnt_n = '0;
        end else if (wait_cnt == TMO_LIMIT) begin
          state_n = ST_ERROR;
        end else if (wait_cnt != {TMO_W{1'b1}}) begin
          wait_cnt_n = wait_cnt + 1'b1;
        end
      end

      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        if_id_flush    = 1'b1;
        // The redirect itself always completes; only MEM and WB hold on a stall.
        if (mem_stall) begin
          en         = 5'b11100;
          state_n    = ST_MEM_WAIT;
          wait_cnt_n = TMO_W'(1);
        end else begin
          en      = 5'b11111;
          state_n = ST_RUN;
        end
      end

      default: begin
        mem_timeout_err = 1'b1;
      end
    endcase

    if (reset) begin
      en              = 5'b00000;
      if_id_flush     = 1'b1;
      id_exe_flush    = 1'b1;
      redirect_valid  = 1'b0;
      mem_timeout_err = 1'b0;
      hazard_evt      = 1'b0;
    end
  end

  assign pc_en      = en[4];
  assign if_id_en   = en[3];
  assign id_exe_en  = en[2];
  assign exe_mem_en = en[1];
  assign mem_wb_en  = en[0];

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hazard_cycles   <= '0;
      mem_wait_cycles <= '0;
    end else begin
      if (hazard_evt) hazard_cycles <= hazard_cycles + 32'd1;
      if (state == ST_MEM_WAIT) mem_wait_cycles <= mem_wait_cycles + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire
